// File: rtl/washer_pkg.sv
// Shared types and constants for the washing-machine plant model.
package washer_pkg;

  // Door interlock states.
  typedef enum logic [1:0] {
    DOOR_CLOSED = 2'd0,
    DOOR_LOCKED = 2'd1,
    DOOR_OPEN   = 2'd2
  } door_state_e;

  // Bit positions inside the sticky err vector.
  localparam int unsigned ERR_FILL_DRAIN = 0;
  localparam int unsigned ERR_WASH_SPIN  = 1;
  localparam int unsigned ERR_OVERFILL   = 2;
  localparam int unsigned ERR_DRY_WASH   = 3;

endpackage

// File: rtl/washer_tank_level.sv
// Tank model: fill/drain prescalers feeding a level register that saturates at 0 and LEVEL_MAX.
module washer_tank_level #(
  parameter int unsigned LEVEL_MAX   = 8,
  parameter int unsigned FILL_TICKS  = 2,
  parameter int unsigned DRAIN_TICKS = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             fill_i,
  input  logic                             drain_i,
  output logic [$clog2(LEVEL_MAX+1)-1:0]   level_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int unsigned LW = $clog2(LEVEL_MAX + 1);
  // One extra bit keeps the width non-zero when a tick count is 1.
  localparam int unsigned FW = $clog2(FILL_TICKS + 1);
  localparam int unsigned DW = $clog2(DRAIN_TICKS + 1);

  localparam logic [LW-1:0] LevelMax  = LW'(LEVEL_MAX);
  localparam logic [FW-1:0] FillLast  = FW'(FILL_TICKS - 1);
  localparam logic [DW-1:0] DrainLast = DW'(DRAIN_TICKS - 1);

  logic [LW-1:0] level_q, level_d;
  logic [FW-1:0] fill_pre_q, fill_pre_d;
  logic [DW-1:0] drain_pre_q, drain_pre_d;

  // Next-state: prescalers clear whenever their condition drops; conflicting commands hold level.
  always_comb begin
    level_d     = level_q;
    fill_pre_d  = '0;
    drain_pre_d = '0;
    if (fill_i && !drain_i) begin
      if (fill_pre_q == FillLast) begin
        if (level_q != LevelMax) begin
          level_d = level_q + 1'b1;
        end
      end else begin
        fill_pre_d = fill_pre_q + 1'b1;
      end
    end else if (drain_i && !fill_i) begin
      if (drain_pre_q == DrainLast) begin
        if (level_q != '0) begin
          level_d = level_q - 1'b1;
        end
      end else begin
        drain_pre_d = drain_pre_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q     <= '0;
      fill_pre_q  <= '0;
      drain_pre_q <= '0;
    end else begin
      level_q     <= level_d;
      fill_pre_q  <= fill_pre_d;
      drain_pre_q <= drain_pre_d;
    end
  end

  assign level_o = level_q;
  assign full_o  = (level_q == LevelMax);
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/washer_plant.sv
// Behavioural washer plant: tank, drying model, door interlock and sticky misuse flags.
module washer_plant
  import washer_pkg::*;
#(
  parameter int unsigned LEVEL_MAX       = 8,
  parameter int unsigned FILL_TICKS      = 2,
  parameter int unsigned DRAIN_TICKS     = 1,
  parameter int unsigned DRY_SPIN_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           water_fill,
  input  logic                           motor_wash,
  input  logic                           motor_spin,
  input  logic                           drain,
  input  logic                           door_req,
  input  logic                           err_clr,
  output logic                           water_full,
  output logic                           drained,
  output logic                           dry_sensor,
  output logic                           door_open,
  output logic [$clog2(LEVEL_MAX+1)-1:0] level,
  output logic [3:0]                     err
);

  localparam int unsigned MW = $clog2(DRY_SPIN_CYCLES + 1);
  localparam logic [MW-1:0] DryInit = MW'(DRY_SPIN_CYCLES);

  logic tank_full, tank_empty;
  logic busy;

  logic [MW-1:0] moist_q, moist_d;
  logic [3:0]    err_q, err_d, err_set;
  door_state_e   door_q, door_d;

  washer_tank_level #(
    .LEVEL_MAX  (LEVEL_MAX),
    .FILL_TICKS (FILL_TICKS),
    .DRAIN_TICKS(DRAIN_TICKS)
  ) u_tank (
    .clk    (clk),
    .rstn   (rstn),
    .fill_i (water_fill),
    .drain_i(drain),
    .level_o(level),
    .full_o (tank_full),
    .empty_o(tank_empty)
  );

  assign busy = water_fill | motor_wash | motor_spin | drain | ~tank_empty;

  // Moisture: any water soaks the load; only spinning an empty tank dries it.
  always_comb begin
    moist_d = moist_q;
    if (!tank_empty) begin
      moist_d = DryInit;
    end else if (motor_spin && (moist_q != '0)) begin
      moist_d = moist_q - 1'b1;
    end
  end

  // Sticky error flags; a fresh set in the same cycle beats err_clr.
  always_comb begin
    err_set                 = '0;
    err_set[ERR_FILL_DRAIN] = water_fill & drain;
    err_set[ERR_WASH_SPIN]  = motor_wash & motor_spin;
    err_set[ERR_OVERFILL]   = water_fill & tank_full;
    err_set[ERR_DRY_WASH]   = motor_wash & tank_empty;
    err_d = err_clr ? err_set : (err_q | err_set);
  end

  // Door interlock next-state; locking has priority over opening.
  always_comb begin
    door_d = door_q;
    case (door_q)
      DOOR_CLOSED: begin
        if (busy) begin
          door_d = DOOR_LOCKED;
        end else if (door_req) begin
          door_d = DOOR_OPEN;
        end
      end
      DOOR_LOCKED: begin
        if (!busy) begin
          door_d = DOOR_CLOSED;
        end
      end
      DOOR_OPEN: begin
        if (!door_req) begin
          door_d = DOOR_CLOSED;
        end
      end
      default: door_d = DOOR_CLOSED;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      moist_q <= '0;
      err_q   <= '0;
      door_q  <= DOOR_CLOSED;
    end else begin
      moist_q <= moist_d;
      err_q   <= err_d;
      door_q  <= door_d;
    end
  end

  assign water_full = tank_full;
  assign drained    = tank_empty;
  assign dry_sensor = (moist_q == '0);
  assign door_open  = (door_q == DOOR_OPEN);
  assign err        = err_q;

endmodule

// File: tb/tb_washer_plant.sv
// Self-checking bench for washer_plant: directed scenarios then random actuator traffic.
module tb_washer_plant;

  localparam int LMAX = 8;
  localparam int FT   = 2;
  localparam int DT   = 1;
  localparam int DRY  = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       water_fill = 1'b0, motor_wash = 1'b0, motor_spin = 1'b0, drain = 1'b0;
  logic       door_req = 1'b0, err_clr = 1'b0;
  logic       water_full, drained, dry_sensor, door_open;
  logic [3:0] level;
  logic [3:0] err;

  int total = 0;
  int bad   = 0;

  // Reference model, expressed as plain counts and flags.
  int         m_level, m_fill_run, m_drain_run, m_moist;
  logic [3:0] m_err;
  bit         m_locked, m_open;

  always #5 clk = ~clk;

  washer_plant #(
    .LEVEL_MAX      (LMAX),
    .FILL_TICKS     (FT),
    .DRAIN_TICKS    (DT),
    .DRY_SPIN_CYCLES(DRY)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .water_fill(water_fill),
    .motor_wash(motor_wash),
    .motor_spin(motor_spin),
    .drain     (drain),
    .door_req  (door_req),
    .err_clr   (err_clr),
    .water_full(water_full),
    .drained   (drained),
    .dry_sensor(dry_sensor),
    .door_open (door_open),
    .level     (level),
    .err       (err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_fill_run = 0; m_drain_run = 0; m_moist = 0;
    m_err = '0; m_locked = 0; m_open = 0;
  endtask

  // Applies the plant rules for one clock edge, all decisions based on pre-edge values.
  task automatic model_step(input bit f, input bit w, input bit s, input bit d, input bit dr,
                            input bit ec);
    int         old_lvl;
    logic [3:0] set;
    bit         busy;
    old_lvl = m_level;
    busy    = f || w || s || d || (old_lvl != 0);
    set     = '0;
    set[0]  = f && d;
    set[1]  = w && s;
    set[2]  = f && (old_lvl == LMAX);
    set[3]  = w && (old_lvl == 0);
    m_err   = ec ? set : (m_err | set);
    if (old_lvl != 0) m_moist = DRY;
    else if (s && m_moist > 0) m_moist = m_moist - 1;
    if (f && !d) begin
      m_drain_run = 0;
      m_fill_run++;
      if (m_fill_run == FT) begin
        m_fill_run = 0;
        if (m_level < LMAX) m_level++;
      end
    end else if (d && !f) begin
      m_fill_run = 0;
      m_drain_run++;
      if (m_drain_run == DT) begin
        m_drain_run = 0;
        if (m_level > 0) m_level--;
      end
    end else begin
      m_fill_run = 0;
      m_drain_run = 0;
    end
    if (m_open) begin
      if (!dr) m_open = 0;
    end else if (m_locked) begin
      if (!busy) m_locked = 0;
    end else if (busy) begin
      m_locked = 1;
    end else if (dr) begin
      m_open = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_full"},  {7'd0, water_full}, {7'd0, m_level == LMAX});
    check({tag, "_drain"}, {7'd0, drained},    {7'd0, m_level == 0});
    check({tag, "_dry"},   {7'd0, dry_sensor}, {7'd0, m_moist == 0});
    check({tag, "_door"},  {7'd0, door_open},  {7'd0, m_open});
    check({tag, "_level"}, {4'd0, level},      8'(m_level));
    check({tag, "_err"},   {4'd0, err},        {4'd0, m_err});
  endtask

  // Drive inputs at the falling edge, clock once, then compare on the next falling edge.
  task automatic step(input string tag, input bit f, input bit w, input bit s, input bit d,
                      input bit dr, input bit ec);
    water_fill = f; motor_wash = w; motor_spin = s; drain = d; door_req = dr; err_clr = ec;
    @(posedge clk);
    model_step(f, w, s, d, dr, ec);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset applied between edges; outputs must follow without a clock.
  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all(tag);
    water_fill = 0; motor_wash = 0; motor_spin = 0; drain = 0; door_req = 0; err_clr = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit f, w, s, d, dr, ec;
    int mode;
    model_reset();

    // Reset values.
    #12;
    check("t1_drained", {7'd0, drained},    8'd1);
    check("t1_full",    {7'd0, water_full}, 8'd0);
    check("t1_dry",     {7'd0, dry_sensor}, 8'd1);
    check("t1_door",    {7'd0, door_open},  8'd0);
    check("t1_level",   {4'd0, level},      8'd0);
    check("t1_err",     {4'd0, err},        8'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Fill to the top: one level every two cycles.
    for (int i = 0; i < 16; i++) begin
      step("t2", 1, 0, 0, 0, 0, 0);
      check("t2_ramp", {4'd0, level}, 8'((i + 1) / 2));
    end
    check("t2_full", {7'd0, water_full}, 8'd1);
    step("t2o", 1, 0, 0, 0, 0, 0);
    check("t2_sat", {4'd0, level}, 8'd8);
    check("t2_overfill", {7'd0, err[2]}, 8'd1);

    // Drain, then spin dry.
    for (int i = 0; i < 8; i++) step("t3d", 0, 0, 0, 1, 0, 0);
    check("t3_drained", {7'd0, drained}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      step("t3s", 0, 0, 1, 0, 0, 0);
      check("t3_dry", {7'd0, dry_sensor}, {7'd0, i == 7});
    end

    // Door held shut while busy, opens two idle edges later.
    step("t4a", 1, 0, 0, 0, 1, 0);
    check("t4_locked", {7'd0, door_open}, 8'd0);
    step("t4b", 0, 0, 0, 0, 1, 0);
    check("t4_closed", {7'd0, door_open}, 8'd0);
    step("t4c", 0, 0, 0, 0, 1, 0);
    check("t4_open", {7'd0, door_open}, 8'd1);
    step("t4d", 0, 0, 0, 0, 0, 0);

    // Conflicting fill and drain at level 4.
    for (int i = 0; i < 8; i++) step("t5f", 1, 0, 0, 0, 0, 0);
    step("t5c", 1, 0, 0, 1, 0, 0);
    step("t5c", 1, 0, 0, 1, 0, 0);
    check("t5_hold", {4'd0, level}, 8'd4);
    step("t5i", 0, 0, 0, 0, 0, 0);
    check("t5_sticky", {7'd0, err[0]}, 8'd1);
    step("t5x", 0, 0, 0, 0, 0, 1);
    check("t5_clr", {4'd0, err}, 8'd0);

    // Reset mid-fill with the door locked, then a dry wash.
    step("t6f", 1, 0, 0, 0, 0, 0);
    step("t6f", 1, 0, 0, 0, 1, 0);
    check("t6_lvl5", {4'd0, level}, 8'd5);
    async_reset("t6r");
    check("t6_rst_level", {4'd0, level}, 8'd0);
    step("t6w", 0, 1, 0, 0, 0, 0);
    check("t6_drywash", {7'd0, err[3]}, 8'd1);

    // Random traffic in bursts biased toward fill, drain, spin, idle or chaos.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) mode = int'($urandom_range(0, 4));
      f = 0; w = 0; s = 0; d = 0;
      case (mode)
        0: begin f = ($urandom_range(0, 99) < 90); w = ($urandom_range(0, 99) < 20); end
        1: begin d = ($urandom_range(0, 99) < 90); s = ($urandom_range(0, 99) < 20); end
        2: begin s = ($urandom_range(0, 99) < 85); end
        3: begin f = ($urandom_range(0, 99) < 3); end
        default: begin
          f = $urandom_range(0, 1) != 0; w = $urandom_range(0, 1) != 0;
          s = $urandom_range(0, 1) != 0; d = $urandom_range(0, 1) != 0;
        end
      endcase
      dr = ($urandom_range(0, 2) == 0);
      ec = ($urandom_range(0, 19) == 0);
      step("rnd", f, w, s, d, dr, ec);
      if ($urandom_range(0, 499) == 0) async_reset("rndrst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
